// File: rtl/dma_responder_if.sv
// Memory-side beat bus of the DMA responder: one request/acknowledge handshake per beat.
// The master drives the request; the slave (memory) returns data, ack and error status.
interface dma_responder_if #(
  parameter int unsigned BEAT_W = 64
) ();

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack,
    output mem_err
  );

endinterface

// File: rtl/dma_responder.sv
// Moves a 1024-bit block between the DMA side and memory as 1024/BEAT_W beats,
// one outstanding beat at a time, with misalignment, bus-error and timeout aborts.
module dma_responder #(
  parameter int unsigned BEAT_W  = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dma_rx_start,
  input  logic            dma_tx_start,
  input  logic [31:0]     dma_rx_address,
  input  logic [31:0]     dma_tx_address,
  input  logic [1023:0]   dma_tx_data,
  output logic [1023:0]   dma_rx_data,
  output logic            dma_done,
  output logic            dma_idle,
  output logic            dma_error,
  dma_responder_if.master mem
);

  localparam int unsigned NumBeats  = 1024 / BEAT_W;
  localparam int unsigned CntW      = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned WaitW     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] BeatBytes = 32'(BEAT_W / 8);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1023:0]   tx_buf_q, tx_buf_d;
  logic [1023:0]   rx_q, rx_d;
  logic            error_q, error_d;

  logic busy;
  logic beat_ack;
  logic last_beat;
  logic timed_out;
  logic abort;

  assign busy      = (state_q == StRead) || (state_q == StWrite);
  // mem_req equals busy, so acks outside a transfer never count.
  assign beat_ack  = busy && mem.mem_ack;
  assign last_beat = (beat_q == CntW'(NumBeats - 1));
  assign timed_out = busy && !mem.mem_ack && (wait_q == WaitW'(TIMEOUT - 1));
  assign abort     = (beat_ack && mem.mem_err) || timed_out;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    tx_buf_d = tx_buf_q;
    rx_d     = rx_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        if (dma_rx_start || dma_tx_start) begin
          error_d = 1'b0;
          beat_d  = '0;
          wait_d  = '0;
          // Read wins a simultaneous start; the write request is dropped.
          if (dma_rx_start) begin
            addr_d   = dma_rx_address;
            tx_buf_d = '0;
            state_d  = StRead;
          end else begin
            addr_d   = dma_tx_address;
            tx_buf_d = dma_tx_data;
            state_d  = StWrite;
          end
          if (addr_d[6:0] != 7'd0) begin
            state_d = StDone;
            error_d = 1'b1;
          end
        end
      end
      StRead, StWrite: begin
        if (abort) begin
          state_d = StDone;
          error_d = 1'b1;
        end else if (beat_ack) begin
          if (state_q == StRead) begin
            rx_d[int'(beat_q) * BEAT_W +: BEAT_W] = mem.mem_rdata;
          end
          wait_d = '0;
          if (last_beat) begin
            state_d = StDone;
          end else begin
            beat_d   = beat_q + CntW'(1);
            addr_d   = addr_q + BeatBytes;
            tx_buf_d = tx_buf_q >> BEAT_W;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
      tx_buf_q <= '0;
      rx_q     <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      tx_buf_q <= tx_buf_d;
      rx_q     <= rx_d;
      error_q  <= error_d;
    end
  end

  assign mem.mem_req   = busy;
  assign mem.mem_we    = (state_q == StWrite);
  assign mem.mem_addr  = addr_q;
  // Write buffer shifts down one beat per ack, so the current beat is always the LSBs.
  assign mem.mem_wdata = tx_buf_q[BEAT_W-1:0];
  assign dma_rx_data   = rx_q;
  assign dma_done      = (state_q == StDone);
  assign dma_idle      = (state_q == StIdle);
  assign dma_error     = error_q;

endmodule

// File: tb/tb_dma_responder.sv
// Directed bench for dma_responder: 64-bit beats, TIMEOUT=8, memory returns its address as data.
module tb_dma_responder;

  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_start, tx_start;
  logic [31:0]   rx_addr, tx_addr;
  logic [1023:0] tx_data, rx_data;
  logic          done, idle, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_responder_if #(.BEAT_W(BEAT_W)) mem_bus ();

  assign mem_bus.mem_rdata = {32'h0, mem_bus.mem_addr};

  dma_responder #(
    .BEAT_W (BEAT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dma_rx_start  (rx_start),
    .dma_tx_start  (tx_start),
    .dma_rx_address(rx_addr),
    .dma_tx_address(tx_addr),
    .dma_tx_data   (tx_data),
    .dma_rx_data   (rx_data),
    .dma_done      (done),
    .dma_idle      (idle),
    .dma_error     (error),
    .mem           (mem_bus)
  );

  function automatic logic [1023:0] rd_block(input logic [31:0] base);
    logic [1023:0] b;
    for (int i = 0; i < 16; i++) b[i*64 +: 64] = {32'h0, base + 32'(i * 8)};
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b1; rx_start = 1'b1; tx_start = 1'b1;
    rx_addr = 32'h1000; tx_addr = 32'h2000; tx_data = '0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", mem_bus.mem_req); end
    checks++; if (mem_bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", mem_bus.mem_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %0b exp 0", error); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b exp 1", idle); end
    checks++; if (mem_bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", mem_bus.mem_addr); end
    checks++; if (mem_bus.mem_wdata !== 64'h0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", mem_bus.mem_wdata); end
    checks++; if (rx_data !== 1024'h0) begin errors++; $display("FAIL rst_rxdata got %0h exp 0", rx_data); end
    reset = 1'b0; rx_start = 1'b0; tx_start = 1'b0; mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_bus.mem_req !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL rst_start_ignored got req %0b idle %0b exp req 0 idle 1", mem_bus.mem_req, idle); end
  endtask

  task automatic test_read();
    int req_n = 0, done_n = 0, done_cyc = 0;
    mem_bus.mem_ack = 1'b1; rx_addr = 32'h1000; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rd_idle_low got %0b exp 0", idle); end
    for (int c = 1; c <= 19; c++) begin
      if (mem_bus.mem_req === 1'b1) begin
        checks++; if (mem_bus.mem_addr !== 32'h1000 + 32'(8 * req_n) || mem_bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_addr got %0h we %0b exp %0h we 0", mem_bus.mem_addr, mem_bus.mem_we, 32'h1000 + 32'(8 * req_n)); end
        req_n++;
      end
      if (done === 1'b1) begin done_n++; done_cyc = c; end
      if (c == 18) begin
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rd_idle_back got %0b exp 1", idle); end
      end
      @(negedge clk);
    end
    checks++; if (req_n != 16) begin errors++; $display("FAIL rd_beats got %0d exp 16", req_n); end
    checks++; if (done_n != 1 || done_cyc != 17) begin errors++; $display("FAIL rd_done got n=%0d cyc=%0d exp n=1 cyc=17", done_n, done_cyc); end
    checks++; if (rx_data[63:0] !== 64'h1000) begin errors++; $display("FAIL rd_low got %0h exp 1000", rx_data[63:0]); end
    checks++; if (rx_data[1023:960] !== 64'h1078) begin errors++; $display("FAIL rd_high got %0h exp 1078", rx_data[1023:960]); end
    checks++; if (rx_data !== rd_block(32'h1000)) begin errors++; $display("FAIL rd_block got %0h exp %0h", rx_data, rd_block(32'h1000)); end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_write();
    int req_n = 0, done_n = 0;
    for (int i = 0; i < 16; i++) tx_data[i*64 +: 64] = 64'(i);
    mem_bus.mem_ack = 1'b1; tx_addr = 32'h2000; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; tx_data = '1;
    for (int c = 1; c <= 19; c++) begin
      if (mem_bus.mem_req === 1'b1) begin
        checks++; if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 32'h2000 + 32'(8 * req_n) || mem_bus.mem_wdata !== 64'(req_n)) begin errors++; $display("FAIL wr_beat got we %0b addr %0h data %0h exp we 1 addr %0h data %0h", mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, 32'h2000 + 32'(8 * req_n), req_n); end
        req_n++;
      end
      if (done === 1'b1) done_n++;
      @(negedge clk);
    end
    checks++; if (req_n != 16 || done_n != 1) begin errors++; $display("FAIL wr_count got beats %0d done %0d exp 16 1", req_n, done_n); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wr_error got %0b exp 0", error); end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_random_ack();
    int dly [16] = '{0, 3, 5, 1, 2, 4, 0, 5, 1, 0, 3, 2, 5, 4, 1, 0};
    int beats = 0, acks = 0, done_n = 0, left;
    for (int i = 0; i < 16; i++) tx_data[i*64 +: 64] = {32'hA5A5_0000, 32'(i)};
    left = dly[0];
    mem_bus.mem_ack = 1'b0; tx_addr = 32'h3000; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (mem_bus.mem_req === 1'b1) begin
        checks++; if (mem_bus.mem_addr !== 32'h3000 + 32'(8 * beats) || mem_bus.mem_wdata !== {32'hA5A5_0000, 32'(beats)}) begin errors++; $display("FAIL rnd_stable got addr %0h data %0h exp addr %0h data %0h", mem_bus.mem_addr, mem_bus.mem_wdata, 32'h3000 + 32'(8 * beats), {32'hA5A5_0000, 32'(beats)}); end
        if (left == 0) begin
          mem_bus.mem_ack = 1'b1; acks++; beats++;
          if (beats < 16) left = dly[beats];
        end else begin
          mem_bus.mem_ack = 1'b0; left--;
        end
      end else begin
        mem_bus.mem_ack = 1'b0;
      end
      if (done === 1'b1) done_n++;
      @(negedge clk);
    end
    checks++; if (acks != 16 || done_n != 1) begin errors++; $display("FAIL rnd_count got acks %0d done %0d exp 16 1", acks, done_n); end
    mem_bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_bus.mem_req !== 1'b0 || done !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL stray_ack got req %0b done %0b idle %0b exp 0 0 1", mem_bus.mem_req, done, idle); end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_mem_err();
    int req_n = 0, done_n = 0;
    logic done_err = 1'b0;
    mem_bus.mem_ack = 1'b1; rx_addr = 32'h4000; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_bus.mem_req === 1'b1) begin
        req_n++;
        mem_bus.mem_err = (mem_bus.mem_addr == 32'h4018);
      end else begin
        mem_bus.mem_err = 1'b0;
      end
      if (done === 1'b1) begin done_n++; done_err = error; end
      @(negedge clk);
    end
    checks++; if (req_n != 4) begin errors++; $display("FAIL err_beats got %0d exp 4", req_n); end
    checks++; if (done_n != 1 || done_err !== 1'b1) begin errors++; $display("FAIL err_done got n=%0d err=%0b exp n=1 err=1", done_n, done_err); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", error); end
    rx_addr = 32'h1000; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", error); end
    repeat (18) @(negedge clk);
    checks++; if (rx_data !== rd_block(32'h1000) || error !== 1'b0) begin errors++; $display("FAIL err_reread got err %0b data %0h exp err 0 data %0h", error, rx_data, rd_block(32'h1000)); end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    rx_addr = 32'h1004; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    checks++; if (mem_bus.mem_req !== 1'b0 || done !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL mis_done got req %0b done %0b err %0b exp 0 1 1", mem_bus.mem_req, done, error); end
    @(negedge clk);
    checks++; if (idle !== 1'b1 || error !== 1'b1 || mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_after got idle %0b err %0b req %0b exp 1 1 0", idle, error, mem_bus.mem_req); end
    checks++; if (rx_data !== rd_block(32'h1000)) begin errors++; $display("FAIL mis_rxdata got %0h exp %0h", rx_data, rd_block(32'h1000)); end
  endtask

  task automatic test_timeout();
    int req_n = 0, done_n = 0, done_cyc = 0;
    mem_bus.mem_ack = 1'b0; rx_addr = 32'h5000; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_bus.mem_req === 1'b1) req_n++;
      if (done === 1'b1) begin done_n++; done_cyc = c; end
      @(negedge clk);
    end
    checks++; if (req_n != 8) begin errors++; $display("FAIL to_req got %0d exp 8", req_n); end
    checks++; if (done_n != 1 || done_cyc != 9) begin errors++; $display("FAIL to_done got n=%0d cyc=%0d exp n=1 cyc=9", done_n, done_cyc); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error got %0b exp 1", error); end
  endtask

  task automatic test_both_starts();
    int req_n = 0, done_n = 0;
    mem_bus.mem_ack = 1'b1; rx_addr = 32'h6000; tx_addr = 32'h7000;
    rx_start = 1'b1; tx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0; tx_start = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL both_err_clear got %0b exp 0", error); end
    for (int c = 1; c <= 19; c++) begin
      tx_start = (c == 3);
      if (mem_bus.mem_req === 1'b1) begin
        checks++; if (mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 32'h6000 + 32'(8 * req_n)) begin errors++; $display("FAIL both_beat got we %0b addr %0h exp we 0 addr %0h", mem_bus.mem_we, mem_bus.mem_addr, 32'h6000 + 32'(8 * req_n)); end
        req_n++;
      end
      if (done === 1'b1) done_n++;
      @(negedge clk);
    end
    tx_start = 1'b0;
    checks++; if (req_n != 16 || done_n != 1) begin errors++; $display("FAIL both_count got beats %0d done %0d exp 16 1", req_n, done_n); end
    checks++; if (mem_bus.mem_req !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL both_noqueue got req %0b idle %0b exp 0 1", mem_bus.mem_req, idle); end
    checks++; if (rx_data !== rd_block(32'h6000)) begin errors++; $display("FAIL both_rxdata got %0h exp %0h", rx_data, rd_block(32'h6000)); end
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    mem_bus.mem_ack = 1'b1; rx_addr = 32'h1000; rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h1038) begin errors++; $display("FAIL rm_beat7 got req %0b addr %0h exp 1 1038", mem_bus.mem_req, mem_bus.mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_bus.mem_req !== 1'b0 || done !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL rm_drop got req %0b done %0b idle %0b exp 0 0 1", mem_bus.mem_req, done, idle); end
    checks++; if (rx_data !== 1024'h0) begin errors++; $display("FAIL rm_cleared got %0h exp 0", rx_data); end
    reset = 1'b0; mem_bus.mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1) done_n++;
      @(negedge clk);
    end
    checks++; if (done_n != 0 || idle !== 1'b1) begin errors++; $display("FAIL rm_after got done %0d idle %0b exp 0 1", done_n, idle); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_random_ack();
    test_mem_err();
    test_misaligned();
    test_timeout();
    test_both_starts();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
